// File: rtl/branch_predictor_bimodal_if.sv
// ============================================================================
// Module : branch_predictor_bimodal_if
// Brief  : Fetch lookup and execute training bus of the branch predictor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface branch_predictor_bimodal_if #(
  parameter int SIZE      = 32,
  parameter int HIST_BITS = 6
);
  logic                 fetch_valid_i;
  logic [SIZE-1:0]      fetch_pc_i;
  logic                 stall_i;
  logic                 prediction_valid_o;
  logic                 branch_prediction_o;
  logic [SIZE-1:0]      pc_value_at_prediction_o;
  logic [HIST_BITS-1:0] ghr_snapshot_o;
  logic                 update_prediction_valid_i;
  logic [SIZE-1:0]      update_prediction_pc_i;
  logic                 update_branch_prediction_i;
  logic                 misprediction_i;
  logic [HIST_BITS-1:0] update_ghr_snapshot_i;

  // Driven by fetch/execute.
  modport master (
    output fetch_valid_i, fetch_pc_i, stall_i,
    output update_prediction_valid_i, update_prediction_pc_i,
    output update_branch_prediction_i, misprediction_i, update_ghr_snapshot_i,
    input  prediction_valid_o, branch_prediction_o, pc_value_at_prediction_o,
    input  ghr_snapshot_o
  );

  // The predictor itself.
  modport slave (
    input  fetch_valid_i, fetch_pc_i, stall_i,
    input  update_prediction_valid_i, update_prediction_pc_i,
    input  update_branch_prediction_i, misprediction_i, update_ghr_snapshot_i,
    output prediction_valid_o, branch_prediction_o, pc_value_at_prediction_o,
    output ghr_snapshot_o
  );
endinterface

`default_nettype wire

// File: rtl/branch_predictor_bimodal.sv
// ============================================================================
// Module : branch_predictor_bimodal
// Brief  : 2-bit saturating-counter branch predictor, registered lookup.
//          Define BP_GSHARE_EN to XOR a global history into the index.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_predictor_bimodal #(
  parameter int SIZE       = 32,
  parameter int INDEX_BITS = 6,
  parameter int HIST_BITS  = 6
) (
  input  wire logic                clk,
  input  wire logic                reset,
  branch_predictor_bimodal_if.slave bp
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [1:0] C_CNT_RESET = 2'b01;

  logic [1:0]            r_table [ENTRIES];
  logic                  r_valid;
  logic                  r_pred;
  logic [SIZE-1:0]       r_pc;
  logic [HIST_BITS-1:0]  r_ghr_snap;

  logic                  w_accept;
  logic                  w_actual;
  logic [INDEX_BITS-1:0] w_lookup_idx;
  logic [INDEX_BITS-1:0] w_upd_idx;
  logic [1:0]            w_lookup_cnt;
  logic [1:0]            w_upd_cnt;
  logic [1:0]            w_upd_next;
  logic                  w_unused;

  assign w_accept = bp.fetch_valid_i & ~bp.stall_i;
  assign w_actual = bp.update_branch_prediction_i ^ bp.misprediction_i;

`ifdef BP_GSHARE_EN
  logic [HIST_BITS-1:0] r_ghr;

  assign w_lookup_idx = bp.fetch_pc_i[INDEX_BITS+1:2] ^ INDEX_BITS'(r_ghr);
  assign w_upd_idx    = bp.update_prediction_pc_i[INDEX_BITS+1:2]
                      ^ INDEX_BITS'(bp.update_ghr_snapshot_i);

  // Misprediction recovery overrides a same-cycle speculative shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ghr      <= '0;
      r_ghr_snap <= '0;
    end else begin
      if (bp.update_prediction_valid_i && bp.misprediction_i)
        r_ghr <= {bp.update_ghr_snapshot_i[HIST_BITS-2:0], w_actual};
      else if (w_accept)
        r_ghr <= {r_ghr[HIST_BITS-2:0], w_lookup_cnt[1]};
      if (w_accept)
        r_ghr_snap <= r_ghr;
    end
  end

  assign w_unused = ^{bp.update_prediction_pc_i, bp.fetch_pc_i};
`else
  assign w_lookup_idx = bp.fetch_pc_i[INDEX_BITS+1:2];
  assign w_upd_idx    = bp.update_prediction_pc_i[INDEX_BITS+1:2];
  assign r_ghr_snap   = '0;
  assign w_unused     = ^{bp.update_prediction_pc_i, bp.update_ghr_snapshot_i};
`endif

  assign w_lookup_cnt = r_table[w_lookup_idx];
  assign w_upd_cnt    = r_table[w_upd_idx];

  always_comb begin
    w_upd_next = w_upd_cnt;
    if (w_actual) begin
      if (w_upd_cnt != 2'b11) w_upd_next = w_upd_cnt + 2'b01;
    end else begin
      if (w_upd_cnt != 2'b00) w_upd_next = w_upd_cnt - 2'b01;
    end
  end

  // Training ignores stall; a same-index lookup this cycle sees the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) r_table[i] <= C_CNT_RESET;
    end else if (bp.update_prediction_valid_i) begin
      r_table[w_upd_idx] <= w_upd_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_pred  <= 1'b0;
      r_pc    <= '0;
    end else if (!bp.stall_i) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_pred <= w_lookup_cnt[1];
        r_pc   <= bp.fetch_pc_i;
      end
    end
  end

  assign bp.prediction_valid_o       = r_valid;
  assign bp.branch_prediction_o      = r_pred;
  assign bp.pc_value_at_prediction_o = r_pc;
  assign bp.ghr_snapshot_o           = r_ghr_snap;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_bimodal.sv
// ============================================================================
// Module : tb_branch_predictor_bimodal
// Brief  : Directed self-checking bench for branch_predictor_bimodal.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor_bimodal;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  branch_predictor_bimodal_if #(.SIZE(32), .HIST_BITS(6)) bp_bus ();

  branch_predictor_bimodal #(
    .SIZE       (32),
    .INDEX_BITS (6),
    .HIST_BITS  (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bp_bus.fetch_valid_i              = 1'b0;
    bp_bus.fetch_pc_i                 = '0;
    bp_bus.stall_i                    = 1'b0;
    bp_bus.update_prediction_valid_i  = 1'b0;
    bp_bus.update_prediction_pc_i     = '0;
    bp_bus.update_branch_prediction_i = 1'b0;
    bp_bus.misprediction_i            = 1'b0;
    bp_bus.update_ghr_snapshot_i      = '0;
  endtask

  task automatic set_lookup(input logic [31:0] pc);
    bp_bus.fetch_valid_i = 1'b1;
    bp_bus.fetch_pc_i    = pc;
  endtask

  task automatic set_update(input logic [31:0] pc, input logic pred, input logic mis,
                            input logic [5:0] snap);
    bp_bus.update_prediction_valid_i  = 1'b1;
    bp_bus.update_prediction_pc_i     = pc;
    bp_bus.update_branch_prediction_i = pred;
    bp_bus.misprediction_i            = mis;
    bp_bus.update_ghr_snapshot_i      = snap;
  endtask

  task automatic lookup(input logic [31:0] pc);
    set_lookup(pc);
    step();
    idle();
  endtask

  task automatic update(input logic [31:0] pc, input logic pred, input logic mis,
                        input logic [5:0] snap);
    set_update(pc, pred, mis, snap);
    step();
    idle();
  endtask

  task automatic async_reset_check(input string tag);
    #2 reset = 1'b0;
    #1;
    check({tag, "_valid"}, 32'(bp_bus.prediction_valid_o), 32'h0);
    check({tag, "_pred"},  32'(bp_bus.branch_prediction_o), 32'h0);
    check({tag, "_pc"},    bp_bus.pc_value_at_prediction_o, 32'h0);
    check({tag, "_ghr"},   32'(bp_bus.ghr_snapshot_o), 32'h0);
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    idle();
    step();
    step();
    check("rst_valid", 32'(bp_bus.prediction_valid_o), 32'h0);
    check("rst_pred",  32'(bp_bus.branch_prediction_o), 32'h0);
    check("rst_pc",    bp_bus.pc_value_at_prediction_o, 32'h0);
    check("rst_ghr",   32'(bp_bus.ghr_snapshot_o), 32'h0);
    reset = 1'b1;
    step();

`ifndef BP_GSHARE_EN
    // 0x100 and 0x200 share index 0; later steps rely on that aliasing.
    lookup(32'h100);
    check("first_valid", 32'(bp_bus.prediction_valid_o), 32'h1);
    check("first_pred",  32'(bp_bus.branch_prediction_o), 32'h0);
    check("first_pc",    bp_bus.pc_value_at_prediction_o, 32'h100);
    step();
    check("nofetch_valid", 32'(bp_bus.prediction_valid_o), 32'h0);
    check("nofetch_pc",    bp_bus.pc_value_at_prediction_o, 32'h100);

    update(32'h100, 1'b0, 1'b1, 6'h0);
    update(32'h100, 1'b0, 1'b1, 6'h0);
    lookup(32'h100);
    check("st_pred", 32'(bp_bus.branch_prediction_o), 32'h1);
    update(32'h100, 1'b1, 1'b1, 6'h0);
    lookup(32'h100);
    check("wt_pred", 32'(bp_bus.branch_prediction_o), 32'h1);

    for (int i = 0; i < 4; i++) update(32'h200, 1'b0, 1'b0, 6'h0);
    update(32'h200, 1'b0, 1'b1, 6'h0);
    lookup(32'h200);
    check("sat00_then_taken_pred", 32'(bp_bus.branch_prediction_o), 32'h0);
    check("sat00_pc", bp_bus.pc_value_at_prediction_o, 32'h200);

    set_lookup(32'h100);
    set_update(32'h100, 1'b0, 1'b1, 6'h0);
    step();
    idle();
    check("nobypass_pred", 32'(bp_bus.branch_prediction_o), 32'h0);
    lookup(32'h100);
    check("after_update_pred", 32'(bp_bus.branch_prediction_o), 32'h1);

    // Stall freezes outputs while training on index 1 still proceeds.
    lookup(32'h104);
    check("stall_pre_pc", bp_bus.pc_value_at_prediction_o, 32'h104);
    bp_bus.stall_i = 1'b1;
    set_lookup(32'h300);
    set_update(32'h104, 1'b0, 1'b1, 6'h0);
    step();
    step();
    bp_bus.update_prediction_valid_i = 1'b0;
    step();
    check("stall_valid", 32'(bp_bus.prediction_valid_o), 32'h1);
    check("stall_pred",  32'(bp_bus.branch_prediction_o), 32'h0);
    check("stall_pc",    bp_bus.pc_value_at_prediction_o, 32'h104);
    idle();
    step();
    check("unstall_valid", 32'(bp_bus.prediction_valid_o), 32'h0);
    check("unstall_pc",    bp_bus.pc_value_at_prediction_o, 32'h104);
    lookup(32'h104);
    check("stall_train_pred", 32'(bp_bus.branch_prediction_o), 32'h1);

    bp_bus.misprediction_i            = 1'b1;
    bp_bus.update_prediction_pc_i     = 32'h108;
    step();
    step();
    idle();
    lookup(32'h108);
    check("jalr_noeffect_pred", 32'(bp_bus.branch_prediction_o), 32'h0);

    update(32'h100, 1'b0, 1'b1, 6'h0);
    lookup(32'h100);
    check("pre_reset_pred", 32'(bp_bus.branch_prediction_o), 32'h1);
    async_reset_check("midrst");
    lookup(32'h100);
    check("post_reset_pred", 32'(bp_bus.branch_prediction_o), 32'h0);
    check("post_reset_valid", 32'(bp_bus.prediction_valid_o), 32'h1);
`else
    // Make the entries reached by history 0, 1, 3 weakly taken.
    update(32'h100, 1'b1, 1'b0, 6'h00);
    update(32'h100, 1'b1, 1'b0, 6'h01);
    update(32'h100, 1'b1, 1'b0, 6'h03);
    lookup(32'h100);
    check("gs_l1_pred", 32'(bp_bus.branch_prediction_o), 32'h1);
    check("gs_l1_snap", 32'(bp_bus.ghr_snapshot_o), 32'h00);
    lookup(32'h100);
    check("gs_l2_snap", 32'(bp_bus.ghr_snapshot_o), 32'h01);
    lookup(32'h100);
    check("gs_l3_pred", 32'(bp_bus.branch_prediction_o), 32'h1);
    check("gs_l3_snap", 32'(bp_bus.ghr_snapshot_o), 32'h03);
    lookup(32'h100);
    check("gs_l4_snap", 32'(bp_bus.ghr_snapshot_o), 32'h07);
    check("gs_l4_pred", 32'(bp_bus.branch_prediction_o), 32'h0);

    update(32'h100, 1'b1, 1'b1, 6'h03);
    lookup(32'h100);
    check("gs_recover_snap", 32'(bp_bus.ghr_snapshot_o), 32'h06);
    check("gs_recover_pred", 32'(bp_bus.branch_prediction_o), 32'h0);

    set_lookup(32'h100);
    set_update(32'h100, 1'b0, 1'b1, 6'h00);
    step();
    idle();
    lookup(32'h100);
    check("gs_recover_wins", 32'(bp_bus.ghr_snapshot_o), 32'h01);

    async_reset_check("gs_midrst");
    lookup(32'h100);
    check("gs_post_reset_snap", 32'(bp_bus.ghr_snapshot_o), 32'h00);
    check("gs_post_reset_pred", 32'(bp_bus.branch_prediction_o), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
